change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Return-path counterpart of the coin-entry buttons (50c/25c/10c) on vending_machine_top.
//  The vend FSM posts the change amount on SUCCESS; this block pays it out greedily, one coin
//  at a time, to the coin hopper via a valid/ack handshake.
//  Then it reports done, or err for an unpayable residue or a hopper timeout.
// PARAMETERS
//  AMT_W        8    width of change_amt in cents (max 255c)
//  GAP_CYCLES   4    idle cycles between coins (hopper settling); 0 = back-to-back
//  ACK_TIMEOUT  1000 cycles coin_valid may wait for coin_ack before abort; 0 = no timeout
// PORTS
//  clk          in   1      system clock (100 MHz)
//  rst          in   1      synchronous, active-high reset
//  change_valid in   1      change request; change_amt valid while high
//  change_amt   in   AMT_W  change to return, in cents
//  change_ready out  1      high only in IDLE; request accepted on change_valid & change_ready
//  coin_valid   out  1      hopper request; held high until coin_ack
//  coin_type    out  2      00=50c 01=25c 10=10c 11=5c; stable while coin_valid is high
//  coin_ack     in   1      hopper has released the coin (sampled only while coin_valid)
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse when a request completes
//  err          out  1      qualifies done: residue <5c left, or ACK timeout
//  remaining    out  AMT_W  cents still owed (registered), for the 7-seg display
// BEHAVIOUR
//  Reset: state=IDLE, remaining=0, gap/timeout counters=0, coin_type=00.
//   Outputs after reset: change_ready=1, coin_valid=busy=done=err=0.
//   A reset in any state aborts immediately; a coin in flight is abandoned with no ack wait.
//  FSM: IDLE -> CALC -> ISSUE -> GAP -> CALC ... -> DONE -> IDLE.
//  IDLE : when change_valid & change_ready: remaining<=change_amt, go to CALC.
//         change_valid in any other state is ignored; it is not queued.
//  CALC : remaining==0 -> DONE (err=0).
//         0<remaining<5 -> DONE (err=1); the residue is dropped and remaining is left as-is.
//         Otherwise coin_type<=largest coin <= remaining (50>25>10>5), go to ISSUE.
//  ISSUE: coin_valid=1. On coin_ack: remaining<=remaining-value(coin_type), no underflow
//           is possible by construction. Then go to GAP, or to CALC if GAP_CYCLES==0.
//         Timeout counter runs from ISSUE entry. Reaching ACK_TIMEOUT without ack ->
//           DONE with err=1; remaining is not decremented.
//         If ack arrives on the timeout cycle, the ack wins.
//  GAP  : count GAP_CYCLES cycles, then go to CALC.
//  DONE : done=1 for exactly one cycle, err valid in the same cycle, then IDLE.
//  Latency: the first coin_valid is 2 cycles after the accept edge.
//           A zero-amount request pulses done 2 cycles after accept, with no coins issued.
//  Coin sequence examples: 15c -> 10,5. 40c -> 25,10,5. 135c -> 50,50,25,10.
//  Arithmetic: unsigned AMT_W-bit. Coin values are AMT_W-bit constants.
//  coin_ack is held high across cycles: it counts once only, because ISSUE exits on the
//   first ack edge.
// STRUCTURE
//  vm_pkg (shared): coin codes COIN_50/25/10/5, coin values in cents, and the dispenser
//   state encodings; vending_machine_top uses the same coin values.
//  Sub-module change_coin_select (combinational): remaining -> {coin_type, coin_ok}.
//   It encodes the greedy choice; coin_ok=0 when remaining<5.
//  Top: FSM, remaining register, gap counter and timeout counter.
// TESTING
//  1 reset held 3 cycles -> change_ready=1, busy=0, remaining=0, coin_valid=0
//  2 amt=15, ack 1 cycle after each coin_valid, GAP=4
//    -> coins 10 then 5; done=1, err=0; remaining=0; no coin_valid during gap
//  3 amt=135
//    -> 50,50,25,10; remaining reads 85,35,10,0 after each ack
//  4 amt=0 -> done 2 cycles after accept, err=0, coin_valid never high
//  5 amt=7 -> one 5c coin, then done with err=1, remaining=2
//  6 amt=50, coin_ack never arrives (ACK_TIMEOUT=20)
//    -> done with err=1 at 20 cycles, remaining=50; rst mid-ISSUE returns to IDLE
//    -> change_valid pulsed while busy is ignored

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions.
//   - Coin codes as driven on the hopper interface (coin_type).
//   - Coin values in cents. vending_machine_top uses the same values.
//   - State encoding of the change dispenser FSM, which is also exported on
//     its debug port.
//   - coin_value(): maps a coin code to its value in cents.
package vm_pkg;

  localparam logic [1:0] COIN_50 = 2'b00;
  localparam logic [1:0] COIN_25 = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_5  = 2'b11;

  localparam int unsigned VAL_50 = 50;
  localparam int unsigned VAL_25 = 25;
  localparam int unsigned VAL_10 = 10;
  localparam int unsigned VAL_5  = 5;

  typedef enum logic [2:0] {
    DISP_IDLE  = 3'd0,
    DISP_CALC  = 3'd1,
    DISP_ISSUE = 3'd2,
    DISP_GAP   = 3'd3,
    DISP_DONE  = 3'd4
  } disp_state_e;

  function automatic int unsigned coin_value(input logic [1:0] code);
    int unsigned val;
    case (code)
      COIN_50: val = VAL_50;
      COIN_25: val = VAL_25;
      COIN_10: val = VAL_10;
      default: val = VAL_5;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin choice for the change dispenser (purely combinational).
// Ports:
//   remaining  in  AMT_W  cents still owed
//   coin_type  out 2      largest coin whose value is <= remaining
//   coin_ok    out 1      0 when remaining < 5c (nothing payable)
// When coin_ok is 0, coin_type reads COIN_5 and must be ignored.
module change_coin_select
  import vm_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  output logic [1:0]       coin_type,
  output logic             coin_ok
);

  always_comb begin
    coin_type = COIN_5;
    coin_ok   = 1'b1;
    if (remaining >= AMT_W'(VAL_50)) begin
      coin_type = COIN_50;
    end else if (remaining >= AMT_W'(VAL_25)) begin
      coin_type = COIN_25;
    end else if (remaining >= AMT_W'(VAL_10)) begin
      coin_type = COIN_10;
    end else if (remaining >= AMT_W'(VAL_5)) begin
      coin_type = COIN_5;
    end else begin
      coin_ok = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change amount greedily, one coin at a time,
// to the coin hopper, then pulses done (with err when a sub-5c residue is
// left or the hopper fails to ack in time).
// Handshakes (valid/ready):
//   request : accepted on the rising clk edge where change_valid & change_ready.
//             change_amt must be valid while change_valid is high. Requests
//             seen while busy are dropped, not queued.
//   hopper  : coin_valid rises with a stable coin_type and stays high until the
//             edge where coin_ack is sampled high. coin_ack is ignored while
//             coin_valid is low.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   change_valid   in   request strobe
//   change_amt     in   change in cents
//   change_ready   out  high only in IDLE
//   coin_valid     out  hopper request
//   coin_type      out  00=50c 01=25c 10=10c 11=5c
//   coin_ack       in   hopper released the coin
//   busy           out  high outside IDLE
//   done           out  one-cycle completion pulse
//   err            out  qualifies done
//   remaining      out  cents still owed (registered)
//   dbg_state      out  FSM state (vm_pkg::disp_state_e encoding)
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  output logic             change_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining,
  output logic [2:0]       dbg_state
);

  // Counters only need to reach N-1; keep at least one bit so a zero
  // parameter still yields legal declarations.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_type_q, coin_type_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q, err_d;

  logic [1:0]       sel_type;
  logic             sel_ok;
  logic [AMT_W-1:0] coin_val;

  change_coin_select #(
    .AMT_W (AMT_W)
  ) u_select (
    .remaining (remaining_q),
    .coin_type (sel_type),
    .coin_ok   (sel_ok)
  );

  // Value of the coin currently in flight; the greedy choice guarantees it
  // never exceeds remaining_q, so the subtraction cannot wrap.
  assign coin_val = AMT_W'(coin_value(coin_type_q));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      coin_type_q <= COIN_50;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      coin_type_q <= coin_type_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_type_d = coin_type_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      DISP_IDLE: begin
        if (change_valid) begin
          remaining_d = change_amt;
          err_d       = 1'b0;
          state_d     = DISP_CALC;
        end
      end

      DISP_CALC: begin
        if (!sel_ok) begin
          // Fully paid, or a residue below 5c that is dropped and left visible.
          err_d   = (remaining_q != '0);
          state_d = DISP_DONE;
        end else begin
          coin_type_d = sel_type;
          to_cnt_d    = '0;
          state_d     = DISP_ISSUE;
        end
      end

      DISP_ISSUE: begin
        // The ack is checked first so it wins over a timeout in the same cycle.
        if (coin_ack) begin
          remaining_d = remaining_q - coin_val;
          gap_cnt_d   = '0;
          state_d     = (GAP_CYCLES == 0) ? DISP_CALC : DISP_GAP;
        end else if (ACK_TIMEOUT != 0) begin
          if (to_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = DISP_DONE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      DISP_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = DISP_CALC;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      DISP_DONE: begin
        state_d = DISP_IDLE;
      end

      default: begin
        state_d = DISP_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    change_ready = (state_q == DISP_IDLE);
    busy         = (state_q != DISP_IDLE);
    coin_valid   = (state_q == DISP_ISSUE);
    done         = (state_q == DISP_DONE);
    err          = (state_q == DISP_DONE) && err_q;
    coin_type    = coin_type_q;
    remaining    = remaining_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed cases plus randomized requests, each
// checked against a greedy payout model built from plain arithmetic.
module tb_change_dispenser;

  localparam int AMT_W = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             change_valid;
  logic [AMT_W-1:0] change_amt;
  logic             change_ready;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             coin_ack;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remaining;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected coin codes and the remaining value after each ack.
  logic [1:0]       exp_q[$];
  logic [AMT_W-1:0] exp_rem_q[$];

  change_dispenser #(
    .AMT_W       (AMT_W),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ready (change_ready),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_ack     (coin_ack),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .remaining    (remaining),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    change_valid = 1'b0;
    change_amt   = '0;
    coin_ack     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", change_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_remaining", remaining, 0);
    check_eq("rst_coin_valid", coin_valid, 0);
    check_eq("rst_done_err", {done, err}, 0);
    check_eq("rst_coin_type", coin_type, 0);
  endtask

  // Greedy payout model. With tmo set, the first coin is never acked.
  task automatic model_build(input int amt, input bit tmo, output int fin_rem, output bit fin_err);
    int vals[4];
    int rem;
    int pick;
    vals = '{50, 25, 10, 5};
    rem  = amt;
    exp_q.delete();
    exp_rem_q.delete();
    while (rem >= 5) begin
      pick = 3;
      for (int k = 3; k >= 0; k--) if (vals[k] <= rem) pick = k;
      exp_q.push_back(2'(pick));
      rem = rem - vals[pick];
      exp_rem_q.push_back(AMT_W'(rem));
    end
    if (tmo) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      exp_rem_q.delete();
      fin_rem = amt;
      fin_err = 1'b1;
    end else begin
      fin_rem = rem;
      fin_err = (rem != 0);
    end
  endtask

  // One request. dly = coin_valid cycles before the ack is raised (>= TMO
  // means no ack). poke pulses change_valid while busy.
  task automatic run_txn(input int amt, input int dly, input bit poke);
    int fin_rem;
    bit fin_err;
    bit tmo;
    bit first;
    bit fin;
    int t;
    int waited;
    int low_run;
    int n_coins;
    tmo = (dly >= TMO) && (amt >= 5);
    model_build(amt, tmo, fin_rem, fin_err);
    @(negedge clk);
    check_eq("ready_idle", change_ready, 1);
    change_valid = 1'b1;
    change_amt   = AMT_W'(amt);
    @(negedge clk);
    change_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    t = 1; waited = 0; low_run = 0; first = 1'b1; fin = 1'b0; n_coins = 0;
    while (!fin && t < 3000) begin
      @(negedge clk);
      t++;
      coin_ack = 1'b0;
      if (poke && t == 3) begin
        change_valid = 1'b1;
        change_amt   = AMT_W'(255);
      end else begin
        change_valid = 1'b0;
      end
      if (coin_valid) begin
        if (waited == 0) begin
          if (first) check_eq("first_coin_latency", t, 2);
          else       check_eq("gap_len", low_run, GAP + 1);
          first = 1'b0;
          n_coins++;
          if (exp_q.size() == 0) check_eq("extra_coin", 1, 0);
          else                   check_eq("coin_type", coin_type, exp_q.pop_front());
        end
        if (waited == dly) coin_ack = 1'b1;
        waited++;
        low_run = 0;
      end else begin
        if (waited > 0) begin
          if (tmo) check_eq("timeout_valid_cycles", waited, TMO);
          else if (exp_rem_q.size() > 0) check_eq("remaining_after_ack", remaining, exp_rem_q.pop_front());
          else check_eq("unexpected_ack", 1, 0);
          waited = 0;
        end
        low_run++;
        if (done) begin
          fin = 1'b1;
          if (n_coins == 0) check_eq("done_latency_nocoin", t, 2);
          else if (tmo)     check_eq("done_after_timeout", low_run, 1);
          else              check_eq("done_after_gap", low_run, GAP + 2);
          check_eq("done_err", err, fin_err);
          check_eq("done_remaining", remaining, fin_rem);
          check_eq("coins_left", exp_q.size(), 0);
        end
      end
    end
    change_valid = 1'b0;
    coin_ack     = 1'b0;
    if (!fin) check_eq("txn_cycle_budget", 0, 1);
    @(negedge clk);
    check_eq("idle_after_done", {change_ready, busy, done}, 3'b100);
  endtask

  // Reset while a coin is in flight: no ack wait, straight back to IDLE.
  task automatic reset_mid_issue();
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = AMT_W'(50);
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    check_eq("issue_before_rst", coin_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_ready", change_ready, 1);
    check_eq("midrst_coin_valid", coin_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_remaining", remaining, 0);
    check_eq("midrst_state", dbg_state, 0);
  endtask

  initial begin
    do_reset();
    run_txn(15, 1, 1'b0);
    run_txn(135, 1, 1'b0);
    run_txn(0, 1, 1'b0);
    run_txn(7, 1, 1'b0);
    run_txn(50, TMO + 5, 1'b1);
    run_txn(50, TMO - 1, 1'b0);
    run_txn(40, 0, 1'b1);
    run_txn(3, 0, 1'b0);
    reset_mid_issue();
    for (int i = 0; i < 30; i++) begin
      int amt;
      int dly;
      amt = $urandom_range(0, 255);
      dly = ($urandom_range(0, 9) == 0) ? TMO + 3 : $urandom_range(0, 6);
      run_txn(amt, dly, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
